stopwatch_ctrl: RTL

//   Mode sequencer for the stopwatch counter datapath. Turns the conditioned user inputs into
//   one-cycle count strobes: debounced pause/reset levels, adjust/select switches, and 1 Hz/2 Hz

---
 rtl/stopwatch_ctrl_if.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between input conditioning / BCD datapath and the stopwatch mode sequencer.
// The master side drives the conditioned inputs; the slave side (sequencer) drives strobes and flags.
interface stopwatch_ctrl_if;
    logic       clr_req;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       btn_pause;
    logic       sw_adj;
    logic       sw_sel;
    logic       sec_at_max;
    logic       inc_sec;
    logic       inc_min;
    logic       clr_all;
    logic [1:0] state_out;
    logic       is_adj;
    logic       is_sel_sec;

    modport master (
        output clr_req, tick_1hz, tick_2hz, btn_pause, sw_adj, sw_sel, sec_at_max,
        input  inc_sec, inc_min, clr_all, state_out, is_adj, is_sel_sec
    );

    modport slave (
        input  clr_req, tick_1hz, tick_2hz, btn_pause, sw_adj, sw_sel, sec_at_max,
        output inc_sec, inc_min, clr_all, state_out, is_adj, is_sel_sec
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: turns debounced buttons, switches and divider ticks into
// one-cycle increment/clear strobes for the BCD counter datapath.
module stopwatch_ctrl #(
    parameter bit RESET_RUNNING = 1'b1,
    parameter bit ADJ_CARRY     = 1'b0
) (
    input  logic           clk_100mhz,
    input  logic           rst_n,
    stopwatch_ctrl_if.slave sw
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        PAUSE   = 2'b01,
        ADJ_MIN = 2'b10,
        ADJ_SEC = 2'b11
    } state_t;

    localparam state_t IDLE_STATE = RESET_RUNNING ? RUN : PAUSE;

    state_t state, state_nxt;
    logic   run_flag, run_nxt;
    logic   clr_q, pause_q, armed;
    logic   inc_sec_q, inc_min_q, clr_all_q;
    logic   inc_sec_nxt, inc_min_nxt, clr_all_nxt;
    logic   clr_edge, pause_edge;
    state_t adj_tgt;

    // Edge detectors stay disarmed for the first cycle out of reset so a
    // button held through reset never produces an event.
    assign clr_edge   = armed & sw.clr_req   & ~clr_q;
    assign pause_edge = armed & sw.btn_pause & ~pause_q;
    assign adj_tgt    = sw.sw_sel ? ADJ_SEC : ADJ_MIN;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE_STATE;
            run_flag  <= RESET_RUNNING;
            clr_q     <= 1'b0;
            pause_q   <= 1'b0;
            armed     <= 1'b0;
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
            clr_all_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_flag  <= run_nxt;
            clr_q     <= sw.clr_req;
            pause_q   <= sw.btn_pause;
            armed     <= 1'b1;
            inc_sec_q <= inc_sec_nxt;
            inc_min_q <= inc_min_nxt;
            clr_all_q <= clr_all_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        run_nxt     = run_flag;
        inc_sec_nxt = 1'b0;
        inc_min_nxt = 1'b0;
        clr_all_nxt = 1'b0;

        if (clr_edge) begin
            // Clear wins over any coincident tick.
            clr_all_nxt = 1'b1;
            run_nxt     = RESET_RUNNING;
            state_nxt   = sw.sw_adj ? adj_tgt : IDLE_STATE;
        end else begin
            // Strobes follow the current state, before any transition.
            case (state)
                RUN: begin
                    inc_sec_nxt = sw.tick_1hz;
                    inc_min_nxt = sw.tick_1hz & sw.sec_at_max;
                end
                ADJ_MIN: inc_min_nxt = sw.tick_2hz;
                ADJ_SEC: begin
                    inc_sec_nxt = sw.tick_2hz;
                    inc_min_nxt = sw.tick_2hz & ADJ_CARRY & sw.sec_at_max;
                end
                default: ;
            endcase

            if (sw.sw_adj) begin
                state_nxt = adj_tgt;
            end else if (state == ADJ_MIN || state == ADJ_SEC) begin
                state_nxt = run_flag ? RUN : PAUSE;
            end else if (pause_edge) begin
                run_nxt   = ~run_flag;
                state_nxt = run_flag ? PAUSE : RUN;
            end
        end
    end

    assign sw.inc_sec    = inc_sec_q;
    assign sw.inc_min    = inc_min_q;
    assign sw.clr_all    = clr_all_q;
    assign sw.state_out  = state;
    assign sw.is_adj     = state[1];
    assign sw.is_sel_sec = (state == ADJ_SEC);

endmodule
